// File: rtl/instr_buffer_pkg.sv
// Shared constants and the pending-fetch entry layout for the instruction fetch queue.
// Entry fields are sized for the widest supported configuration; the top zero-extends into them.
package instr_buffer_pkg;

    localparam int IFQ_NUM_CH    = 4;
    localparam int IFQ_ADDR_W    = 32;
    localparam int IFQ_TAG_W     = 39;
    localparam int IFQ_DEPTH     = 4;
    localparam int IFQ_MEM_BYTES = 4096;

    localparam int FETCH_NARROW_BYTES = 4;
    localparam int FETCH_WIDE_BYTES   = 8;

    localparam int ENTRY_ADDR_W = 64;
    localparam int ENTRY_TAG_W  = 64;
    localparam int ENTRY_CH_W   = 3;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_TAG_W-1:0]  tag;
        logic                    wide;
        logic [ENTRY_CH_W-1:0]   ch;
    } fetch_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
// The pointer moves just past the granted channel whenever the grant is taken.
module rr_arbiter
    import instr_buffer_pkg::*;
#(
    parameter int NUM_CH = IFQ_NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Multi-channel instruction fetch queue: arbitrated requests enter a FIFO and are served
// in order from a byte-addressed instruction memory with a registered response stage.
module instr_fetch_queue
    import instr_buffer_pkg::*;
#(
    parameter int NUM_CH    = IFQ_NUM_CH,
    parameter int ADDR_W    = IFQ_ADDR_W,
    parameter int TAG_W     = IFQ_TAG_W,
    parameter int DEPTH     = IFQ_DEPTH,
    parameter int MEM_BYTES = IFQ_MEM_BYTES
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_CH-1:0]                            req_valid,
    output logic [NUM_CH-1:0]                            req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]                     req_addr,
    input  logic [NUM_CH*TAG_W-1:0]                      req_tag,
    input  logic [NUM_CH-1:0]                            req_wide,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [63:0]                                  rsp_instr,
    output logic [TAG_W-1:0]                             rsp_tag,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rsp_ch,
    output logic                                         rsp_err,
    input  logic                                         ld_en,
    input  logic [ADDR_W-1:0]                            ld_addr,
    input  logic [31:0]                                  ld_data,
    output logic [$clog2(DEPTH+1)-1:0]                   count
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORDS  = MEM_BYTES / 4;
    localparam int WORD_W = $clog2(WORDS);

    logic [NUM_CH-1:0] grant;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [CH_W-1:0]   sel_ch;
    logic [ADDR_W-1:0] sel_addr;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_wide;
    fetch_entry_t      entry;

    fetch_entry_t      fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    fetch_entry_t      head;

    logic [31:0]       imem [WORDS];

    logic [ADDR_W-1:0] head_addr;
    logic [ADDR_W:0]   head_end;
    logic [WORD_W-1:0] head_word;
    logic              misalign;
    logic              rd_err;
    logic [31:0]       rd_lo;
    logic [31:0]       rd_hi;
    logic [63:0]       rd_instr;

    logic [WORD_W-1:0] ld_word;
    logic              ld_ok;
    logic              unused_bits;

    // Request stage: arbitrate among channels and enqueue the winner
    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (push),
        .grant   (grant)
    );

    // Fullness is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = (rst && !full) ? grant : '0;
    assign push      = |(req_valid & req_ready);
    assign pop       = !empty && (!rsp_valid || rsp_ready);

    always_comb begin
        sel_ch   = '0;
        sel_addr = '0;
        sel_tag  = '0;
        sel_wide = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_ch   = CH_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
                sel_wide = req_wide[i];
            end
        end
        entry      = '0;
        entry.addr = ENTRY_ADDR_W'(sel_addr);
        entry.tag  = ENTRY_TAG_W'(sel_tag);
        entry.wide = sel_wide;
        entry.ch   = ENTRY_CH_W'(sel_ch);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Response stage: read the head entry from memory and register the result
    assign head      = fifo_mem[rd_ptr];
    assign head_addr = head.addr[ADDR_W-1:0];
    assign head_word = head_addr[WORD_W+1:2];
    assign head_end  = {1'b0, head_addr} + (head.wide ? (ADDR_W+1)'(FETCH_WIDE_BYTES)
                                                      : (ADDR_W+1)'(FETCH_NARROW_BYTES));
    assign misalign  = head.wide ? (head_addr[2:0] != 3'b000) : (head_addr[1:0] != 2'b00);
    assign rd_err    = misalign || (head_end > (ADDR_W+1)'(MEM_BYTES));

    // A valid wide fetch starts on an even word, so its upper half is always the odd neighbour.
    assign rd_lo    = imem[head_word];
    assign rd_hi    = imem[head_word | WORD_W'(1)];
    assign rd_instr = rd_err    ? 64'h0 :
                      head.wide ? {rd_hi, rd_lo} : {32'h0, rd_lo};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_tag   <= '0;
            rsp_ch    <= '0;
            rsp_err   <= 1'b0;
        end else if (pop) begin
            rsp_valid <= 1'b1;
            rsp_instr <= rd_instr;
            rsp_tag   <= head.tag[TAG_W-1:0];
            rsp_ch    <= head.ch[CH_W-1:0];
            rsp_err   <= rd_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Memory is never reset; reads above are combinational so a same-edge load is seen only later.
    assign ld_word = ld_addr[WORD_W+1:2];
    assign ld_ok   = ld_addr[ADDR_W-1:2] < (ADDR_W-2)'(WORDS);

    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) begin
            imem[ld_word] <= ld_data;
        end
    end

    assign unused_bits = ^{head, ld_addr[1:0]};

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a cycle model predicts handshakes and
// occupancy while a scoreboard queue holds expected responses in acceptance order.
module tb_instr_fetch_queue;

    localparam int NUM_CH    = 4;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = 39;
    localparam int DEPTH     = 4;
    localparam int MEM_BYTES = 4096;
    localparam int CH_W      = 2;
    localparam int CNT_W     = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_CH-1:0]        req_valid = '0;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
    logic [NUM_CH*TAG_W-1:0]  req_tag = '0;
    logic [NUM_CH-1:0]        req_wide = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic [63:0]              rsp_instr;
    logic [TAG_W-1:0]         rsp_tag;
    logic [CH_W-1:0]          rsp_ch;
    logic                     rsp_err;
    logic                     ld_en = 1'b0;
    logic [ADDR_W-1:0]        ld_addr = '0;
    logic [31:0]              ld_data = '0;
    logic [CNT_W-1:0]         count;

    typedef struct {
        logic [63:0]      instr;
        logic [TAG_W-1:0] tag;
        int               ch;
        bit               err;
    } exp_t;

    exp_t        sb_q[$];
    int          ch_log[$];
    logic [63:0] instr_log[$];
    logic [7:0]  mm [MEM_BYTES];

    int errors   = 0;
    int checks   = 0;
    int ptr_m    = 0;
    int cnt_m    = 0;
    bit vld_m    = 0;
    int hs_total = 0;

    instr_fetch_queue #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .TAG_W     (TAG_W),
        .DEPTH     (DEPTH),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_tag   (req_tag),
        .req_wide  (req_wide),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_tag   (rsp_tag),
        .rsp_ch    (rsp_ch),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input int unsigned a, input bit w,
                                      input logic [TAG_W-1:0] t, input int ch);
        exp_t        e;
        int unsigned sz;
        sz      = w ? 8 : 4;
        e.tag   = t;
        e.ch    = ch;
        e.instr = '0;
        e.err   = (w ? (a % 8 != 0) : (a % 4 != 0)) || (a + sz > MEM_BYTES);
        if (!e.err) begin
            for (int b = 0; b < int'(sz); b++) e.instr[8*b +: 8] = mm[a + b];
        end
        return e;
    endfunction

    // Evaluated at the falling edge: checks current DUT state, then advances the model
    // to what it should be after the next rising edge.
    task automatic model_step();
        logic [NUM_CH-1:0] rdy;
        int   gi;
        int   idx;
        bit   found;
        bit   hs;
        bit   popm;
        exp_t e;
        rdy   = '0;
        gi    = 0;
        found = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (ptr_m + k) % NUM_CH;
            if (!found && req_valid[idx]) begin
                found = 1;
                gi    = idx;
            end
        end
        if (rst && found && cnt_m < DEPTH) rdy[gi] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(vld_m));
        chk("count", 64'(count), 64'(cnt_m));
        if (vld_m && sb_q.size() > 0) begin
            e = sb_q[0];
            chk("rsp_instr", rsp_instr, e.instr);
            chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            chk("rsp_ch", 64'(rsp_ch), 64'(e.ch));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
        if (!rst) begin
            sb_q.delete();
            cnt_m = 0;
            vld_m = 0;
            ptr_m = 0;
        end else begin
            hs   = |(req_valid & rdy);
            popm = (cnt_m > 0) && (!vld_m || rsp_ready);
            if (vld_m && rsp_ready) begin
                ch_log.push_back(int'(rsp_ch));
                instr_log.push_back(rsp_instr);
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
            if (hs) begin
                sb_q.push_back(make_exp(req_addr[gi*ADDR_W +: ADDR_W], req_wide[gi],
                                        req_tag[gi*TAG_W +: TAG_W], gi));
                ptr_m = (gi + 1) % NUM_CH;
                hs_total++;
            end
            cnt_m = cnt_m + (hs ? 1 : 0) - (popm ? 1 : 0);
            vld_m = popm ? 1'b1 : (rsp_ready ? 1'b0 : vld_m);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic load(input int unsigned a, input logic [31:0] d);
        int unsigned base;
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        base  = a & ~32'd3;
        if (base + 4 <= MEM_BYTES) begin
            for (int b = 0; b < 4; b++) mm[base + b] = d[8*b +: 8];
        end
    endtask

    task automatic set_req(input int ch, input int unsigned a, input bit w, input logic [TAG_W-1:0] t);
        req_addr[ch*ADDR_W +: ADDR_W] = a;
        req_tag[ch*TAG_W +: TAG_W]    = t;
        req_wide[ch]                  = w;
        req_valid[ch]                 = 1'b1;
    endtask

    task automatic fetch(input int ch, input int unsigned a, input bit w, input logic [TAG_W-1:0] t);
        bit got;
        got = 0;
        set_req(ch, a, w, t);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1;
        end
        @(posedge clk);
        #1;
        req_valid[ch] = 1'b0;
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget && hs_total < target; i++) begin
            @(posedge clk);
            #1;
        end
        if (hs_total < target) chk("handshake_timeout", 64'(hs_total), 64'(target));
    endtask

    initial begin
        int base;
        int order[6];
        order = '{0, 1, 2, 3, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_count", 64'(count), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_instr", rsp_instr, 64'(0));
        chk("reset_rsp_tag", 64'(rsp_tag), 64'(0));
        chk("reset_rsp_ch", 64'(rsp_ch), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        @(posedge clk);
        #1;

        load(0, 32'h3333_3333);
        load(4, 32'h0D0C_0B0A);
        load(8, 32'h1111_1111);
        load(12, 32'h2222_2222);
        for (int i = 0; i < NUM_CH; i++) load(16 + 4 * i, 32'hC0DE_0000 + i);
        load(MEM_BYTES - 4, 32'hA5A5_5A5A);
        load(MEM_BYTES, 32'hDEAD_BEEF);

        // All channels requesting continuously, pointer fresh from reset
        ch_log.delete();
        base = hs_total;
        for (int i = 0; i < NUM_CH; i++) set_req(i, 16 + 4 * i, 1'b0, 39'(8'h10 + i));
        wait_hs(base + 6, 50);
        req_valid = '0;
        drain(40);
        chk("rr_len", 64'(ch_log.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < ch_log.size()) chk("rr_order", 64'(ch_log[i]), 64'(order[i]));
        end

        // Single narrow fetch and its two-cycle latency
        fetch(0, 4, 1'b0, 39'd1);
        @(negedge clk);
        chk("lat_k1_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        chk("lat_k2_valid", 64'(rsp_valid), 64'(1));
        chk("lat_instr", rsp_instr, 64'h0000_0000_0D0C_0B0A);
        chk("lat_tag", 64'(rsp_tag), 64'(1));
        chk("lat_ch", 64'(rsp_ch), 64'(0));
        chk("lat_err", 64'(rsp_err), 64'(0));
        @(posedge clk);
        #1;
        drain(20);

        // Wide, misaligned and boundary fetches
        instr_log.delete();
        fetch(1, 8, 1'b1, 39'h55);
        fetch(2, 4, 1'b1, 39'h56);
        fetch(3, MEM_BYTES - 4, 1'b0, 39'h57);
        fetch(0, MEM_BYTES - 4, 1'b1, 39'h58);
        fetch(1, 6, 1'b0, 39'h59);
        fetch(2, 0, 1'b0, 39'h5A);
        drain(40);
        if (instr_log.size() == 6) begin
            chk("wide_ok_instr", instr_log[0], 64'h2222_2222_1111_1111);
            chk("wide_mis_instr", instr_log[1], 64'h0);
            chk("top_narrow_instr", instr_log[2], 64'h0000_0000_A5A5_5A5A);
            chk("oob_load_ignored", instr_log[5], 64'h0000_0000_3333_3333);
        end else begin
            chk("edge_len", 64'(instr_log.size()), 64'(6));
        end

        // Backpressure: one response held while the FIFO fills
        ch_log.delete();
        rsp_ready = 1'b0;
        base = hs_total;
        for (int i = 0; i < NUM_CH; i++) set_req(i, 16 + 4 * i, 1'b0, 39'(8'h20 + i));
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_count", 64'(count), 64'(DEPTH));
        chk("bp_ready", 64'(req_ready), 64'(0));
        chk("bp_valid", 64'(rsp_valid), 64'(1));
        chk("bp_accepted", 64'(hs_total - base), 64'(5));
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain(40);
        chk("bp_released", 64'(ch_log.size()), 64'(5));

        // Mid-operation reset with queued work
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) set_req(i, 16 + 4 * i, 1'b0, 39'(8'h30 + i));
        for (int i = 0; i < 30 && cnt_m < 3; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        chk("pre_reset_count", 64'(cnt_m), 64'(3));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_count", 64'(count), 64'(0));
        chk("mid_reset_valid", 64'(rsp_valid), 64'(0));
        chk("mid_reset_instr", rsp_instr, 64'(0));
        chk("mid_reset_tag", 64'(rsp_tag), 64'(0));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        ch_log.delete();
        instr_log.delete();
        base = hs_total;
        set_req(2, 24, 1'b0, 39'h62);
        set_req(0, 4, 1'b0, 39'h60);
        wait_hs(base + 2, 20);
        req_valid = '0;
        drain(30);
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_len", 64'(ch_log.size()), 64'(2));
        if (ch_log.size() >= 2) begin
            chk("post_reset_first_ch", 64'(ch_log[0]), 64'(0));
            chk("post_reset_mem", instr_log[0], 64'h0000_0000_0D0C_0B0A);
            chk("post_reset_second_ch", 64'(ch_log[1]), 64'(2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesting wavefront channels, range 1-8.
REQ-002 Parameter ADDR_W, default 32: fetch/load address width.
REQ-003 Parameter TAG_W, default 39: opaque wave tag width, returned unmodified.
REQ-004 Parameter DEPTH, default 4: pending-request FIFO depth, a power of two, at least 2.
REQ-005 Parameter MEM_BYTES, default 4096: instruction memory size in bytes, a multiple of 8.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 req_valid  in  NUM_CH  per-channel fetch request.
REQ-009 req_ready  out  NUM_CH  per-channel accept; a handshake occurs when valid and ready are both high.
REQ-010 req_addr  in  NUM_CH*ADDR_W  byte address; channel i occupies slice i.
REQ-011 req_tag  in  NUM_CH*TAG_W  tag per channel.
REQ-012 req_wide  in  NUM_CH  1 = 64-bit fetch, 0 = 32-bit fetch.
REQ-013 rsp_valid  out  1  response valid.
REQ-014 rsp_ready  in  1  response consumed.
REQ-015 rsp_instr  out  64  instruction data.
REQ-016 rsp_tag  out  TAG_W  tag of the request.
REQ-017 rsp_ch  out  clog2(NUM_CH), minimum 1  originating channel.
REQ-018 rsp_err  out  1  misaligned or out-of-range fetch.
REQ-019 ld_en, ld_addr (ADDR_W), ld_data (32)  in  memory load port: 32-bit word write; ld_addr[1:0] ignored.
REQ-020 count  out  clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-021 Arbitration: round-robin among channels with req_valid high; priority pointer is 0 after reset and moves to (granted+1) mod NUM_CH after each handshake.
REQ-022 req_ready: at most one bit high per cycle, only for the granted channel, and only when the FIFO is not full. It is combinational from req_valid, the pointer and count.
REQ-023 Full is evaluated before any same-cycle pop, so a full FIFO accepts nothing even when popping.
REQ-024 Handshake: the entry {addr, tag, wide, ch} is pushed at the edge.
REQ-025 Pop: when the FIFO is non-empty and (rsp_valid==0 or rsp_ready==1), the head is popped, memory is read, and the rsp_* registers load at that edge.
REQ-026 Minimum latency: a handshake in cycle k gives rsp_valid in cycle k+2.
REQ-027 Responses are in acceptance order.
REQ-028 When rsp_valid==1 and rsp_ready==0, all rsp_* outputs hold stable.
REQ-029 When rsp_ready==1 and nothing is poppable, rsp_valid drops at the next edge.
REQ-030 Byte order is little-endian: 32-bit fetch gives rsp_instr = {32'h0, m[a+3], m[a+2], m[a+1], m[a]}; 64-bit fetch gives the 8 bytes m[a+7..a].
REQ-031 rsp_err=1 and rsp_instr=0 on any of: 32-bit fetch with a[1:0]!=0; 64-bit fetch with a[2:0]!=0; a+size > MEM_BYTES. Tag and ch are still returned.
REQ-032 Load: on ld_en, the word at ld_addr & ~3 is written. Out-of-range loads are ignored.
REQ-033 A load and a pop reading the same word in the same cycle: the pop returns the old data (read-before-write).
REQ-034 count increments on push, decrements on pop, and is unchanged on simultaneous push and pop.

Reset
REQ-035 While rst==0 at an edge: FIFO emptied, count=0, pointer=0, rsp_valid=0, rsp_instr=0, rsp_tag=0, rsp_ch=0, rsp_err=0.
REQ-036 req_ready is all zero during any cycle with rst==0.
REQ-037 Memory contents are not reset and persist across reset.
REQ-038 Reset mid-operation discards pending and held responses; no response appears for them afterward.

Structure
REQ-039 Package instr_buffer_pkg holds the default parameter constants, the FIFO entry struct typedef, and the fetch-size constants (4, 8).
REQ-040 Round-robin arbitration is a sub-module, rr_arbiter (parameter NUM_CH; inputs req and advance; output one-hot grant).
REQ-041 FIFO and memory stay in the top module.

Verification
REQ-042 Load 0x0D0C0B0A at address 4; ch0 requests addr 4, tag 1, narrow -> two cycles later rsp_instr=0x000000000D0C0B0A, tag=1, ch=0, err=0.
REQ-043 All four channels hold req_valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1 and the matching rsp_ch sequence.
REQ-044 rsp_ready=0 for 10 cycles with sustained requests -> one response held stable, count reaches 4, req_ready=0; after release, 5 responses in acceptance order.
REQ-045 Words 0x11111111 at address 8 and 0x22222222 at address 12; wide fetch at 8 -> rsp_instr=0x2222222211111111. Wide fetch at 4 -> err=1, instr=0.
REQ-046 Narrow fetch at MEM_BYTES-4 -> err=0. Wide fetch at MEM_BYTES-4 -> err=1. Narrow fetch at address 6 -> err=1.
REQ-047 rst=0 for one cycle with 3 queued entries -> count=0, rsp_valid=0, next grant goes to ch0, previously loaded memory still reads back correctly.
